// File: rtl/decoder_pkg.sv
// Shared types, mode encodings and the one-hot helper for the decoder_scan family.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } dec_state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest select the helper supports; callers cast the result down to 2**IN_W bits.
  localparam int ONEHOT_SEL_W = 8;
  localparam int ONEHOT_W     = 2 ** ONEHOT_SEL_W;

  // One-hot of sel at full helper width; the caller picks the low 2**IN_W bits.
  function automatic logic [ONEHOT_W-1:0] onehot(input logic [ONEHOT_SEL_W-1:0] sel);
    return ONEHOT_W'(1) << sel;
  endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational N-to-2^N decoder with an enable; all-zero output when disabled.
module decoder_onehot
  import decoder_pkg::*;
#(
  parameter  int IN_W  = 3,
  localparam int OUT_W = 2 ** IN_W
) (
  input  logic             en,
  input  logic [IN_W-1:0]  sel,
  output logic [OUT_W-1:0] dec
);

  // Decode sel to a single hot line, or nothing when the enable is low.
  always_comb begin
    dec = '0;
    if (en) dec = OUT_W'(onehot(ONEHOT_SEL_W'(sel)));
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with direct and autonomous scan modes.
// Optional feature: define DECODER_SCAN_ONESHOT_EN to stop after a single sweep
// instead of scanning continuously.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter  int IN_W    = 3,
  parameter  int DWELL_W = 4,
  localparam int OUT_W   = 2 ** IN_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               E,
  input  logic               mode,
  input  logic               start,
  input  logic [IN_W-1:0]    In,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   Out,
  output logic [IN_W-1:0]    idx,
  output logic               busy,
  output logic               wrap
);

  localparam logic [IN_W-1:0] IDX_LAST = IN_W'(OUT_W - 1);

  dec_state_t         state, state_next;
  logic [IN_W-1:0]    idx_next;
  logic [DWELL_W-1:0] cnt, cnt_next;
  logic               wrap_next;
  logic [IN_W-1:0]    dec_sel;
  logic               dec_en;
  logic [OUT_W-1:0]   dec_out;

  // Next-state logic: abort has priority over mode change, which beats stepping.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    wrap_next  = 1'b0;
    case (state)
      IDLE: begin
        idx_next = '0;
        cnt_next = '0;
        if (E && mode == MODE_DIRECT) begin
          state_next = DIRECT;
        end else if (E && mode == MODE_SCAN && start) begin
          state_next = SCAN;
          cnt_next   = dwell;
        end
      end
      DIRECT: begin
        idx_next = '0;
        cnt_next = '0;
        if (!E || mode == MODE_SCAN) state_next = IDLE;
      end
      SCAN: begin
        if (!E || mode != MODE_SCAN) begin
          state_next = IDLE;
          idx_next   = '0;
          cnt_next   = '0;
        end else if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else if (idx != IDX_LAST) begin
          idx_next = idx + 1'b1;
          cnt_next = dwell;
        end else begin
          wrap_next = 1'b1;
          idx_next  = '0;
`ifdef DECODER_SCAN_ONESHOT_EN
          cnt_next   = '0;
          state_next = IDLE;
`else
          cnt_next = dwell;
`endif
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
        cnt_next   = '0;
      end
    endcase
  end

  // Output line comes from the state being entered so every output is a plain flop.
  always_comb begin
    dec_en  = (state_next != IDLE);
    dec_sel = (state_next == DIRECT) ? In : idx_next;
  end

  decoder_onehot #(.IN_W(IN_W)) u_onehot (
    .en  (dec_en),
    .sel (dec_sel),
    .dec (dec_out)
  );

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      Out   <= '0;
      busy  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      Out   <= dec_out;
      busy  <= (state_next == SCAN);
      wrap  <= wrap_next;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: directed scenarios plus randomized traffic
// compared every cycle against a line/hold-time reference model.
module tb_decoder_scan;

  localparam int IN_W    = 3;
  localparam int DWELL_W = 4;
  localparam int OUT_W   = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               E = 1'b0;
  logic               mode = 1'b0;
  logic               start = 1'b0;
  logic [IN_W-1:0]    In = '0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [OUT_W-1:0]   Out;
  logic [IN_W-1:0]    idx;
  logic               busy;
  logic               wrap;

  int n_checks = 0;
  int n_passed = 0;

  // Reference model: activity is off / direct / scanning; a scan shows one line
  // for line_len cycles, counting cycles shown so far in held.
  int         m_activity = 0;
  int         m_line = 0;
  int         m_held = 0;
  int         m_len = 1;
  logic [7:0] m_out = '0;
  logic [2:0] m_idx = '0;
  logic       m_busy = 1'b0;
  logic       m_wrap = 1'b0;

  decoder_scan #(.IN_W(IN_W), .DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .E     (E),
    .mode  (mode),
    .start (start),
    .In    (In),
    .dwell (dwell),
    .Out   (Out),
    .idx   (idx),
    .busy  (busy),
    .wrap  (wrap)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    else
      n_passed++;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic updateModel();
    m_wrap = 1'b0;
    if (rst) begin
      m_activity = 0;
    end else begin
      case (m_activity)
        0: begin
          if (E && !mode) m_activity = 1;
          else if (E && mode && start) begin
            m_activity = 2;
            m_line     = 0;
            m_held     = 0;
            m_len      = int'(dwell) + 1;
          end
        end
        1: if (!E || mode) m_activity = 0;
        default: begin
          if (!E || !mode) m_activity = 0;
          else begin
            m_held++;
            if (m_held == m_len) begin
              m_held = 0;
              m_len  = int'(dwell) + 1;
              if (m_line == OUT_W - 1) begin
                m_wrap = 1'b1;
                m_line = 0;
`ifdef DECODER_SCAN_ONESHOT_EN
                m_activity = 0;
`endif
              end else begin
                m_line++;
              end
            end
          end
        end
      endcase
    end
    if (m_activity != 2) m_line = 0;
    m_idx  = 3'(m_line);
    m_busy = (m_activity == 2);
    m_out  = (m_activity == 1) ? (8'd1 << In) :
             (m_activity == 2) ? (8'd1 << m_line) : 8'd0;
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare all outputs.
  task automatic applyStimulus(input logic r, input logic e, input logic m, input logic s,
                               input logic [IN_W-1:0] sel, input logic [DWELL_W-1:0] dw);
    @(negedge clk);
    rst   = r;
    E     = e;
    mode  = m;
    start = s;
    In    = sel;
    dwell = dw;
    @(posedge clk);
    updateModel();
    #1;
    checkOutput("Out", 32'(Out), 32'(m_out));
    checkOutput("idx", 32'(idx), 32'(m_idx));
    checkOutput("busy", 32'(busy), 32'(m_busy));
    checkOutput("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  logic e_r, mode_r;

  initial begin
    // Reset with random inputs on the other pins.
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
                    3'($urandom), 4'($urandom));
    checkOutput("rst_out", 32'(Out), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    // Direct decode: 5 then 2, then disable.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 4'd0);
    checkOutput("dir5", 32'(Out), 32'h20);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 4'd0);
    checkOutput("dir2", 32'(Out), 32'h04);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'd0);
    checkOutput("dir_off", 32'(Out), 32'h00);

    // Scan with dwell 0: one cycle per line.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 4'd0);
    checkOutput("scan_first", 32'(Out), 32'h01);
    for (int i = 1; i <= OUT_W; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0);
      if (i < OUT_W) checkOutput("walk", 32'(Out), 32'(8'd1 << i));
    end
    checkOutput("walk_wrap", 32'(wrap), 32'd1);
`ifdef DECODER_SCAN_ONESHOT_EN
    checkOutput("oneshot_out", 32'(Out), 32'h00);
    checkOutput("oneshot_busy", 32'(busy), 32'd0);
`else
    checkOutput("wrap_out", 32'(Out), 32'h01);
    checkOutput("wrap_busy", 32'(busy), 32'd1);
`endif

    // Dwell 3: full sweep of 32 cycles ends on the wrap.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 4'd3);
    for (int i = 1; i <= 32; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd3);
      if (i == 4) checkOutput("dwell_line1", 32'(idx), 32'd1);
    end
    checkOutput("dwell_sweep_wrap", 32'(wrap), 32'd1);

    // Dwell change mid-line applies from the next line.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 4'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd3);
    for (int i = 2; i <= 6; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd1);
      if (i == 3) checkOutput("dwchg_hold", 32'(idx), 32'd0);
      if (i == 4) checkOutput("dwchg_next", 32'(idx), 32'd1);
      if (i == 6) checkOutput("dwchg_short", 32'(idx), 32'd2);
    end

    // Abort at idx 4 by switching to direct mode.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 4'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0);
    checkOutput("abort_at4", 32'(idx), 32'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 4'd0);
    checkOutput("abort_out", 32'(Out), 32'h00);
    checkOutput("abort_idx", 32'(idx), 32'd0);
    checkOutput("abort_wrap", 32'(wrap), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 4'd0);
    checkOutput("abort_direct", 32'(Out), 32'h08);

    // Reset mid-scan at idx 6 with start held high (ignored in scan).
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 4'd0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 4'd0);
    checkOutput("start_ignored", 32'(idx), 32'd6);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 4'd0);
    checkOutput("rst_mid_out", 32'(Out), 32'h00);
    checkOutput("rst_mid_idx", 32'(idx), 32'd0);
    checkOutput("rst_mid_wrap", 32'(wrap), 32'd0);

    // Randomized traffic with sticky mode/enable so scans get to run.
    e_r    = 1'b1;
    mode_r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) e_r = ~e_r;
      if ($urandom_range(0, 23) == 0) mode_r = ~mode_r;
      applyStimulus(($urandom_range(0, 99) == 0), e_r, mode_r,
                    ($urandom_range(0, 3) == 0), 3'($urandom),
                    4'($urandom_range(0, 3)));
    end

    $display("[TB] %0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered N-to-2^N one-hot decoder with an autonomous scan mode, the successor to the fixed 2-to-4 and 3-to-8 decoders. In direct mode it registers the one-hot decode of `In`. In scan mode an internal index sweeps every output line in turn, holding each one for a programmable dwell time. It drives channel-select and strobe fan-out for downstream banks.

## Interface
- `IN_W`, default 3: select width; output width `OUT_W = 2**IN_W`.
- `DWELL_W`, default 4: width of the dwell-time field.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst` input, 1: reset, synchronous, active-high.
- `E` input, 1: enable; 0 forces the block to IDLE.
- `mode` input, 1: 0 = direct decode, 1 = scan.
- `start` input, 1: launches a scan when in IDLE with `E=1` and `mode=1`.
- `In` input, `IN_W`: select input for direct mode.
- `dwell` input, `DWELL_W`: each scan step lasts `dwell+1` cycles; sampled at every step reload.
- `Out` output, `OUT_W`: registered one-hot output, or all zero.
- `idx` output, `IN_W`: current scan index (registered).
- `busy` output, 1: high while in SCAN.
- `wrap` output, 1: one-cycle pulse when the index moves from `OUT_W-1` to 0, or when a one-shot sweep finishes.

## Operation
- Reset values: `Out=0`, `idx=0`, `busy=0`, `wrap=0`, state IDLE, dwell counter 0.
- States: IDLE, DIRECT, SCAN.
- **IDLE:** `Out=0`.
  - `E & ~mode` → DIRECT.
  - `E & mode & start` → SCAN, loading `idx<=0` and `cnt<=dwell`.
  - Otherwise stay in IDLE.
- **DIRECT:**
  - Each cycle `Out <= 1<<In`.
  - `~E` or `mode` → IDLE with `Out<=0`. A scan needs a fresh `start` from IDLE.
- **SCAN:** `Out = 1<<idx`.
  - If `cnt != 0`: `cnt <= cnt-1`.
  - If `cnt == 0` and `idx != OUT_W-1`: `idx <= idx+1`, `cnt <= dwell`.
  - If `cnt == 0` and `idx == OUT_W-1`: `wrap<=1`, `idx<=0`, `cnt<=dwell`. See Configuration for the one-shot variant.
  - `start` is ignored while in SCAN.
- **Abort:** `~E` or `~mode` in SCAN → IDLE next edge: `Out<=0`, `idx<=0`, `busy<=0`, and no `wrap` pulse.
- **Precedence:** `rst` > abort (`~E`) > mode change > step/wrap.
- **Arithmetic:** `idx` wraps naturally at `2**IN_W`; `cnt` is `DWELL_W` bits and never underflows.
- **Dwell edge cases:** `dwell=0` gives one cycle per line. A `dwell` change takes effect at the next reload only.

## Timing
- Every output is a flop; there is no combinational path from inputs to outputs.
- Direct latency is 1 cycle: `In` sampled at edge t appears on `Out` after edge t.
- Scan start: `start` sampled at edge t → after edge t, `Out=...0001`, `busy=1`, `idx=0`.
- Each line is held `dwell+1` cycles. One full sweep takes `OUT_W*(dwell+1)` cycles.
- `wrap` is high for exactly the one cycle in which `Out` returns to bit 0 (or, in one-shot, goes to 0).
- Reset mid-scan: after the `rst` edge, all outputs are at their reset values with no `wrap` pulse.

## Configuration
- Macro: `DECODER_SCAN_ONESHOT_EN`.
- **Defined:**
  - At end of sweep (`cnt==0`, `idx==OUT_W-1`): `wrap<=1`, then state → IDLE with `Out<=0`, `busy<=0`, `idx<=0`.
  - A new sweep needs `start` again; holding `start` high relaunches on the edge after the return to IDLE.
- **Undefined:** continuous scanning, wrapping `OUT_W-1` → 0 indefinitely until abort.

## Structure
- Package `decoder_pkg` holds:
  - state enum `dec_state_t` {IDLE, DIRECT, SCAN};
  - `MODE_DIRECT=1'b0`, `MODE_SCAN=1'b1`;
  - function `onehot(sel)` returning `1<<sel`, parametrised by width.
- Sub-module `decoder_onehot #(IN_W)`: combinational enable + N-to-2^N decode. It is instantiated once, with its output registered in `decoder_scan`.

## Test plan
All scenarios use IN_W=3 and DWELL_W=4.
- **Reset:** hold `rst` 2 cycles with random inputs → `Out=0`, `idx=0`, `busy=0`, `wrap=0`.
- **Direct:** `E=1`, `mode=0`, `In` = 5, then 2 → `Out=8'h20` one cycle after `In=5`, then `8'h04`. Dropping `E=0` → `Out=0` next cycle.
- **Scan, dwell=0:**
  - Without macro: `start` pulse → `Out` walks `01,02,…,80,01` one cycle each, `wrap` high with the second `01`, `busy=1` throughout.
  - With macro: after `80`, `Out=0`, `wrap=1`, `busy=0`.
- **Dwell:** `dwell=3` → each line held 4 cycles; one sweep = 32 cycles. Changing to `dwell=1` mid-line → takes effect from the next line.
- **Abort:** mid-scan at `idx=4`, set `mode=0` → next cycle `Out=0`, `idx=0`, `busy=0`, no `wrap`; state then reaches DIRECT the following edge.
- **Reset mid-scan:** assert `rst` at `idx=6` → reset values next cycle. `start` during SCAN has no effect on `idx`.
